// File: rtl/ram_port_arb.sv
// ram_port_arb: shares one single-port RAM between two requesters.
//
// Purpose
//   Port 0 (UART command controller) and port 1 (second on-chip master) each
//   present read/write commands over a valid/ready handshake. A round-robin
//   arbiter grants at most one command per clock. The granted command is
//   registered onto the RAM pins. Read data comes back to the issuing port a
//   fixed 1+RD_LAT cycles after acceptance.
//
// Ports
//   sys_clk, rst_n            clock (rising edge), asynchronous active-low reset
//   reqN_valid/write/addr/wdata  command from requester N
//   reqN_ready                combinational grant, command accepted this cycle
//   reqN_rvalid/rdata         one-cycle read-return pulse and data for port N
//   ram_write/addr/datain     registered RAM command (write is a 1-cycle pulse)
//   ram_dataout               RAM read data, valid RD_LAT clocks after the
//                             edge that samples ram_addr
module ram_port_arb #(
    parameter int unsigned AW     = 8,
    parameter int unsigned DW     = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          sys_clk,
    input  logic          rst_n,

    input  logic          req0_valid,
    input  logic          req0_write,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    output logic          req0_ready,
    output logic          req0_rvalid,
    output logic [DW-1:0] req0_rdata,

    input  logic          req1_valid,
    input  logic          req1_write,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    output logic          req1_ready,
    output logic          req1_rvalid,
    output logic [DW-1:0] req1_rdata,

    output logic          ram_write,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_datain,
    input  logic [DW-1:0] ram_dataout
);

    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
        $error("ram_port_arb: RD_LAT must be in 1..4");
    end

    // Port that won the most recent accept; 1 after reset so port 0 wins
    // the first tie.
    logic last;

    logic          grant0;
    logic          grant1;
    logic          accept;
    logic          sel;
    logic          sel_write;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    // Read tag pipeline: stage 0 is loaded at the accept edge, stage RD_LAT
    // lines up with ram_dataout for that read.
    logic [RD_LAT:0] tag_rd;
    logic [RD_LAT:0] tag_port;
    logic            ret0;
    logic            ret1;

    // Round-robin grant. Readies are held low during reset so nothing can
    // be accepted against a register bank that is being cleared.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n) begin
            if (req0_valid && req1_valid) begin
                grant0 = last;
                grant1 = ~last;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign accept     = grant0 | grant1;
    assign sel        = grant1;

    always_comb begin
        if (sel) begin
            sel_write = req1_write;
            sel_addr  = req1_addr;
            sel_wdata = req1_wdata;
        end else begin
            sel_write = req0_write;
            sel_addr  = req0_addr;
            sel_wdata = req0_wdata;
        end
    end

    assign ret0 = tag_rd[RD_LAT] & ~tag_port[RD_LAT];
    assign ret1 = tag_rd[RD_LAT] & tag_port[RD_LAT];

    // Arbitration state and RAM command registers.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            last       <= 1'b1;
            ram_write  <= 1'b0;
            ram_addr   <= '0;
            ram_datain <= '0;
        end else begin
            ram_write <= accept & sel_write;
            if (accept) begin
                last       <= sel;
                ram_addr   <= sel_addr;
                ram_datain <= sel_wdata;
            end
        end
    end

    // Tag pipeline: one entry per clock, bubbles for writes and idle cycles.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_rd   <= '0;
            tag_port <= '0;
        end else begin
            tag_rd   <= {tag_rd[RD_LAT-1:0], accept & ~sel_write};
            tag_port <= {tag_port[RD_LAT-1:0], sel};
        end
    end

    // Read return: pulse rvalid on the owning port; the other port's rdata
    // keeps its last returned value.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            req0_rvalid <= 1'b0;
            req1_rvalid <= 1'b0;
            req0_rdata  <= '0;
            req1_rdata  <= '0;
        end else begin
            req0_rvalid <= ret0;
            req1_rvalid <= ret1;
            if (ret0) begin
                req0_rdata <= ram_dataout;
            end
            if (ret1) begin
                req1_rdata <= ram_dataout;
            end
        end
    end

endmodule

// File: tb/tb_ram_port_arb.sv
// Bench for ram_port_arb. Two instances share the same stimulus: one with
// RD_LAT=1 and one with RD_LAT=2, each with its own synchronous RAM model.
// A transaction-level model (accept order, memory array, return list)
// predicts grants, RAM pins and read returns every cycle.
module tb_ram_port_arb;

    logic clk = 1'b0;
    logic rst_n;
    logic clr;

    logic       v0, w0, v1, w1;
    logic [7:0] a0, d0, a1, d1;

    logic       rdy0 [2];
    logic       rdy1 [2];
    logic       rv0  [2];
    logic       rv1  [2];
    logic [7:0] rd0  [2];
    logic [7:0] rd1  [2];
    logic       ram_wr [2];
    logic [7:0] ram_a  [2];
    logic [7:0] ram_di [2];

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [7:0] mem  [256];
        logic [7:0] pipe [0:g];
        logic [7:0] dout;

        ram_port_arb #(.AW(8), .DW(8), .RD_LAT(g + 1)) u_dut (
            .sys_clk     (clk),
            .rst_n       (rst_n),
            .req0_valid  (v0),
            .req0_write  (w0),
            .req0_addr   (a0),
            .req0_wdata  (d0),
            .req0_ready  (rdy0[g]),
            .req0_rvalid (rv0[g]),
            .req0_rdata  (rd0[g]),
            .req1_valid  (v1),
            .req1_write  (w1),
            .req1_addr   (a1),
            .req1_wdata  (d1),
            .req1_ready  (rdy1[g]),
            .req1_rvalid (rv1[g]),
            .req1_rdata  (rd1[g]),
            .ram_write   (ram_wr[g]),
            .ram_addr    (ram_a[g]),
            .ram_datain  (ram_di[g]),
            .ram_dataout (dout)
        );

        // Synchronous RAM with g+1 output register stages.
        always @(posedge clk) begin
            if (clr) begin
                for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            end else if (ram_wr[g]) begin
                mem[ram_a[g]] <= ram_di[g];
            end
            pipe[0] <= mem[ram_a[g]];
            for (int i = 1; i <= g; i++) pipe[i] <= pipe[i-1];
        end
        assign dout = pipe[g];
    end

    // ---------------- reference model ----------------
    typedef struct {
        int         dut;
        int         due;
        bit         port;
        logic [7:0] data;
    } ret_t;

    ret_t       m_q[$];
    logic [7:0] m_mem [256];
    logic [7:0] m_rd  [2][2];
    bit         m_last;
    bit         m_wr;
    logic [7:0] m_addr, m_din, m_undo;
    int         cyc = 0;

    task automatic chk(input string name, input int k, input logic [7:0] act,
                       input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d: got %0h expected %0h", name, k, act, exp);
    endtask

    task automatic model_reset();
        // A write still waiting on the RAM pins never lands.
        if (m_wr) m_mem[m_addr] = m_undo;
        m_last = 1'b1;
        m_wr   = 1'b0;
        m_addr = 8'h00;
        m_din  = 8'h00;
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < 2; p++) m_rd[k][p] = 8'h00;
        m_q.delete();
    endtask

    task automatic model_grant(output bit g0, output bit g1);
        g0 = 1'b0;
        g1 = 1'b0;
        if (v0 && v1) begin
            if (m_last) g0 = 1'b1;
            else        g1 = 1'b1;
        end else if (v0) g0 = 1'b1;
        else if (v1)     g1 = 1'b1;
    endtask

    task automatic model_edge(input bit g0, input bit g1);
        bit p, w;
        logic [7:0] a, d;
        cyc++;
        if (g0 || g1) begin
            p = g1;
            w = p ? w1 : w0;
            a = p ? a1 : a0;
            d = p ? d1 : d0;
            m_last = p;
            m_wr   = w;
            m_addr = a;
            m_din  = d;
            if (w) begin
                m_undo   = m_mem[a];
                m_mem[a] = d;
            end else begin
                for (int k = 0; k < 2; k++)
                    m_q.push_back('{dut: k, due: cyc + 2 + k, port: p, data: m_mem[a]});
            end
        end else begin
            m_wr = 1'b0;
        end
    endtask

    task automatic chk_reset_outputs(input string name);
        for (int k = 0; k < 2; k++) begin
            chk({name, "_ready0"}, k, 8'(rdy0[k]), 8'h00);
            chk({name, "_ready1"}, k, 8'(rdy1[k]), 8'h00);
            chk({name, "_ram_write"}, k, 8'(ram_wr[k]), 8'h00);
            chk({name, "_ram_addr"}, k, ram_a[k], 8'h00);
            chk({name, "_ram_datain"}, k, ram_di[k], 8'h00);
            chk({name, "_rvalid0"}, k, 8'(rv0[k]), 8'h00);
            chk({name, "_rvalid1"}, k, 8'(rv1[k]), 8'h00);
            chk({name, "_rdata0"}, k, rd0[k], 8'h00);
            chk({name, "_rdata1"}, k, rd1[k], 8'h00);
        end
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic tick(output bit g0, output bit g1, output logic [1:0] ar0,
                        output logic [1:0] ar1);
        bit ev;
        logic [7:0] ed;
        #1;
        model_grant(g0, g1);
        for (int k = 0; k < 2; k++) begin
            ar0[k] = rdy0[k];
            ar1[k] = rdy1[k];
            chk("ready0", k, 8'(rdy0[k]), 8'(g0));
            chk("ready1", k, 8'(rdy1[k]), 8'(g1));
            chk("one_ready", k, 8'(rdy0[k] & rdy1[k]), 8'h00);
        end
        @(posedge clk);
        #1;
        model_edge(g0, g1);
        for (int k = 0; k < 2; k++) begin
            chk("ram_write", k, 8'(ram_wr[k]), 8'(m_wr));
            chk("ram_addr", k, ram_a[k], m_addr);
            chk("ram_datain", k, ram_di[k], m_din);
            for (int p = 0; p < 2; p++) begin
                ev = 1'b0;
                foreach (m_q[i])
                    if (m_q[i].dut == k && m_q[i].due == cyc && m_q[i].port == p[0]) begin
                        ev = 1'b1;
                        m_rd[k][p] = m_q[i].data;
                    end
                ed = m_rd[k][p];
                if (p == 0) begin
                    chk("rvalid0", k, 8'(rv0[k]), 8'(ev));
                    chk("rdata0", k, rd0[k], ed);
                end else begin
                    chk("rvalid1", k, 8'(rv1[k]), 8'(ev));
                    chk("rdata1", k, rd1[k], ed);
                end
            end
        end
        for (int i = m_q.size() - 1; i >= 0; i--)
            if (m_q[i].due <= cyc) m_q.delete(i);
        @(negedge clk);
    endtask

    task automatic set_in(input logic iv0, input logic iw0, input logic [7:0] ia0,
                          input logic [7:0] id0, input logic iv1, input logic iw1,
                          input logic [7:0] ia1, input logic [7:0] id1);
        v0 = iv0; w0 = iw0; a0 = ia0; d0 = id0;
        v1 = iv1; w1 = iw1; a1 = ia1; d1 = id1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic       v0, w0;
        logic [7:0] a0, d0;
        logic       v1, w1;
        logic [7:0] a1, d1;
        logic       er0, er1;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic iv0, input logic iw0, input logic [7:0] ia0,
                       input logic [7:0] id0, input logic iv1, input logic iw1,
                       input logic [7:0] ia1, input logic [7:0] id1,
                       input logic er0, input logic er1);
        tbl.push_back({iv0, iw0, ia0, id0, iv1, iw1, ia1, id1, er0, er1});
    endtask

    function automatic logic [7:0] rand_addr();
        if ($urandom_range(0, 9) == 0) return 8'hFF;
        return 8'($urandom_range(0, 7));
    endfunction

    initial begin
        bit g0, g1;
        logic [1:0] ar0, ar1;

        for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
        model_reset();

        // Port 0 write, port 1 read of the same address.
        add(1, 1, 8'h10, 8'hA5, 0, 0, 8'h00, 8'h00, 1, 0);
        add(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0);
        add(0, 0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h00, 0, 1);
        repeat (3) add(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0);
        // Both ports contend: grants alternate, each holds until accepted.
        add(1, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'hB0, 1, 0);
        add(1, 0, 8'h01, 8'h00, 1, 1, 8'h20, 8'hB0, 0, 1);
        add(1, 0, 8'h01, 8'h00, 1, 1, 8'h21, 8'hB1, 1, 0);
        add(1, 0, 8'h02, 8'h00, 1, 1, 8'h21, 8'hB1, 0, 1);
        add(1, 0, 8'h02, 8'h00, 1, 1, 8'h22, 8'hB2, 1, 0);
        add(0, 0, 8'h00, 8'h00, 1, 1, 8'h22, 8'hB2, 0, 1);
        // Preload 0..3, then four back-to-back reads.
        add(1, 1, 8'h00, 8'h11, 0, 0, 8'h00, 8'h00, 1, 0);
        add(1, 1, 8'h01, 8'h22, 0, 0, 8'h00, 8'h00, 1, 0);
        add(1, 1, 8'h02, 8'h33, 0, 0, 8'h00, 8'h00, 1, 0);
        add(1, 1, 8'h03, 8'h44, 0, 0, 8'h00, 8'h00, 1, 0);
        add(1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0);
        add(1, 0, 8'h01, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0);
        add(1, 0, 8'h02, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0);
        add(1, 0, 8'h03, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0);
        // Read immediately after write to the same address.
        add(1, 1, 8'h30, 8'h77, 0, 0, 8'h00, 8'h00, 1, 0);
        add(1, 0, 8'h30, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0);
        repeat (4) add(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0);
        // Port 1 alone at the top address, then port 0 joins and wins the tie.
        add(0, 0, 8'h00, 8'h00, 1, 1, 8'hFF, 8'h5A, 0, 1);
        add(0, 0, 8'h00, 8'h00, 1, 0, 8'hFF, 8'h00, 0, 1);
        add(1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00, 1, 0);
        add(0, 0, 8'h00, 8'h00, 1, 0, 8'h02, 8'h00, 0, 1);
        repeat (4) add(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0);

        // Reset with both valid high: readies must stay low.
        rst_n = 1'b0;
        clr   = 1'b1;
        set_in(1, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00);
        #1;
        chk_reset_outputs("init");
        @(posedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
        set_in(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            set_in(tbl[i].v0, tbl[i].w0, tbl[i].a0, tbl[i].d0,
                   tbl[i].v1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
            tick(g0, g1, ar0, ar1);
            for (int k = 0; k < 2; k++) begin
                chk("tbl_ready0", k, 8'(ar0[k]), 8'(tbl[i].er0));
                chk("tbl_ready1", k, 8'(ar1[k]), 8'(tbl[i].er1));
            end
        end

        // Reset one cycle after a read accept: the read is dropped.
        set_in(1, 0, 8'h03, 8'h00, 0, 0, 8'h00, 8'h00);
        tick(g0, g1, ar0, ar1);
        set_in(1, 0, 8'h00, 8'h00, 1, 0, 8'h01, 8'h00);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick(g0, g1, ar0, ar1);
        for (int k = 0; k < 2; k++) begin
            chk("tie_after_reset0", k, 8'(ar0[k]), 8'h01);
            chk("tie_after_reset1", k, 8'(ar1[k]), 8'h00);
        end
        set_in(0, 0, 8'h00, 8'h00, 1, 0, 8'h01, 8'h00);
        tick(g0, g1, ar0, ar1);
        set_in(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        repeat (4) tick(g0, g1, ar0, ar1);

        // Random traffic; each requester holds its command until accepted.
        repeat (400) begin
            if (!v0 && $urandom_range(0, 2) != 0) begin
                v0 = 1'b1;
                w0 = 1'($urandom_range(0, 1));
                a0 = rand_addr();
                d0 = 8'($urandom);
            end
            if (!v1 && $urandom_range(0, 2) != 0) begin
                v1 = 1'b1;
                w1 = 1'($urandom_range(0, 1));
                a1 = rand_addr();
                d1 = 8'($urandom);
            end
            tick(g0, g1, ar0, ar1);
            if (g0) v0 = 1'b0;
            if (g1) v1 = 1'b0;
        end
        set_in(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        repeat (5) tick(g0, g1, ar0, ar1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
